// File: rtl/dist_ascii_pkg.sv
// Shared types, ASCII constants and frame layout for the distance-to-ASCII formatter.
// Define DIST_UNIT_EN to append the "cm" unit suffix to every frame.
package dist_ascii_pkg;

    typedef enum logic [1:0] {StIdle, StConv, StSend} tx_state_e;
    typedef enum logic [1:0] {CvIdle, CvHund, CvTens} conv_state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_C  = 8'h63;
    localparam logic [7:0] ASCII_M  = 8'h6D;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned DIST_MAX = 999;

`ifdef DIST_UNIT_EN
    localparam int unsigned FRAME_LEN = 7;
`else
    localparam int unsigned FRAME_LEN = 5;
`endif
    localparam int unsigned IDX_W = $clog2(FRAME_LEN);

    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [3:0] hund,
                                              input logic [3:0] tens,
                                              input logic [3:0] ones);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            IDX_W'(0): b = ASCII_0 + 8'(hund);
            IDX_W'(1): b = ASCII_0 + 8'(tens);
            IDX_W'(2): b = ASCII_0 + 8'(ones);
`ifdef DIST_UNIT_EN
            IDX_W'(3): b = ASCII_C;
            IDX_W'(4): b = ASCII_M;
            IDX_W'(5): b = ASCII_CR;
            IDX_W'(6): b = ASCII_LF;
`else
            IDX_W'(3): b = ASCII_CR;
            IDX_W'(4): b = ASCII_LF;
`endif
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dist_bin2dec.sv
// Binary-to-three-digit decimal converter using repeated subtraction of 100 then 10.
// i_start loads the (clamped) distance; o_done is high in the final tens cycle.
module dist_bin2dec
    import dist_ascii_pkg::*;
#(
    parameter int unsigned DIST_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DIST_W-1:0] i_dist,
    output logic              o_done,
    output logic [3:0]        o_hund,
    output logic [3:0]        o_tens,
    output logic [3:0]        o_ones
);

    localparam int unsigned REM_W = (DIST_W > 10) ? DIST_W : 10;

    conv_state_e      r_state;
    conv_state_e      w_state_d;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_dist_ext;
    logic [REM_W-1:0] w_load;
    logic [3:0]       r_hund;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             w_ge100;
    logic             w_ge10;

    assign w_dist_ext = REM_W'(i_dist);

    // Narrow inputs can never exceed 999, so the clamp is only built when it can matter.
    generate
        if (DIST_W >= 10) begin : g_clamp
            assign w_load = (w_dist_ext > REM_W'(DIST_MAX)) ? REM_W'(DIST_MAX) : w_dist_ext;
        end else begin : g_no_clamp
            assign w_load = w_dist_ext;
        end
    endgenerate

    assign w_ge100 = (r_rem >= REM_W'(100));
    assign w_ge10  = (r_rem >= REM_W'(10));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CvIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            CvIdle:  if (i_start) w_state_d = CvHund;
            CvHund:  if (!w_ge100) w_state_d = CvTens;
            CvTens:  if (!w_ge10) w_state_d = CvIdle;
            default: w_state_d = CvIdle;
        endcase
    end

    always_comb begin
        o_done = (r_state == CvTens) && !w_ge10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_hund <= '0;
            r_tens <= '0;
            r_ones <= '0;
        end else begin
            case (r_state)
                CvIdle: begin
                    if (i_start) begin
                        r_rem  <= w_load;
                        r_hund <= '0;
                        r_tens <= '0;
                        r_ones <= '0;
                    end
                end
                CvHund: begin
                    if (w_ge100) begin
                        r_rem  <= r_rem - REM_W'(100);
                        r_hund <= r_hund + 4'd1;
                    end
                end
                CvTens: begin
                    if (w_ge10) begin
                        r_rem  <= r_rem - REM_W'(10);
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_ones <= r_rem[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hund = r_hund;
    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/dist_ascii_tx.sv
// Formats one distance measurement as a fixed-length ASCII frame and pushes it into a TX FIFO.
// Define DIST_UNIT_EN to include the "cm" suffix (7-byte frame instead of 5).
module dist_ascii_tx
    import dist_ascii_pkg::*;
#(
    parameter int unsigned DIST_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] i_dist,
    input  logic              i_dist_valid,
    input  logic              tx_fifo_full,
    output logic [7:0]        tx_fifo_data,
    output logic              tx_fifo_push,
    output logic              o_busy,
    output logic              o_drop
);

    tx_state_e        r_state;
    tx_state_e        w_state_d;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       r_data;
    logic             r_busy;
    logic             r_drop;
    logic             w_start;
    logic             w_done;
    logic             w_last;
    logic [3:0]       w_hund;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;

    dist_bin2dec #(
        .DIST_W (DIST_W)
    ) u_bin2dec (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_dist  (i_dist),
        .o_done  (w_done),
        .o_hund  (w_hund),
        .o_tens  (w_tens),
        .o_ones  (w_ones)
    );

    assign w_last    = (r_idx == IDX_W'(FRAME_LEN - 1));
    assign w_idx_nxt = r_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (i_dist_valid) w_state_d = StConv;
            StConv:  if (w_done) w_state_d = StSend;
            StSend:  if (tx_fifo_push && w_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_start      = (r_state == StIdle) && i_dist_valid;
        tx_fifo_push = (r_state == StSend) && !tx_fifo_full;
    end

    // Byte 0 is registered as conversion finishes so it is on the bus in the first SEND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_data <= 8'h00;
            r_busy <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_busy <= (w_state_d != StIdle);
            r_drop <= i_dist_valid && (r_state != StIdle);
            if ((r_state == StConv) && w_done) begin
                r_idx  <= '0;
                r_data <= frame_byte(IDX_W'(0), w_hund, w_tens, w_ones);
            end else if (tx_fifo_push && !w_last) begin
                r_idx  <= w_idx_nxt;
                r_data <= frame_byte(w_idx_nxt, w_hund, w_tens, w_ones);
            end
        end
    end

    assign tx_fifo_data = r_data;
    assign o_busy       = r_busy;
    assign o_drop       = r_drop;

endmodule

// File: tb/tb_dist_ascii_tx.sv
// Self-checking bench for dist_ascii_tx: cycle model of the frame protocol plus directed frames.
// Honours DIST_UNIT_EN the same way as the design.
module tb_dist_ascii_tx;

    localparam int unsigned DIST_W = 10;
`ifdef DIST_UNIT_EN
    localparam int TB_LEN = 7;
`else
    localparam int TB_LEN = 5;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DIST_W-1:0] i_dist;
    logic              i_dist_valid;
    logic              tx_fifo_full;
    logic [7:0]        tx_fifo_data;
    logic              tx_fifo_push;
    logic              o_busy;
    logic              o_drop;

    always #5 clk = ~clk;

    dist_ascii_tx #(
        .DIST_W (DIST_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_dist       (i_dist),
        .i_dist_valid (i_dist_valid),
        .tx_fifo_full (tx_fifo_full),
        .tx_fifo_data (tx_fifo_data),
        .tx_fifo_push (tx_fifo_push),
        .o_busy       (o_busy),
        .o_drop       (o_drop)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: one frame in flight, a countdown until sending, and the frame bytes.
    bit         m_ok = 1'b0;
    bit         m_active = 1'b0;
    bit         m_drop = 1'b0;
    int         m_wait = 0;
    int         m_idx = 0;
    logic [7:0] m_frame [0:6];
    int         cyc = 0;
    int         accept_cyc = 0;
    int         first_push_cyc = -1;
    int         drop_cnt = 0;
    logic [7:0] rx_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int d;
        cyc++;
        if (m_ok) begin
            check("busy", {31'b0, o_busy}, {31'b0, m_active});
            check("drop", {31'b0, o_drop}, {31'b0, m_drop});
            check("push", {31'b0, tx_fifo_push},
                  {31'b0, (m_active && m_wait == 0 && !tx_fifo_full)});
            if (m_active && m_wait == 0) check("data", {24'b0, tx_fifo_data}, {24'b0, m_frame[m_idx]});
        end
        if (tx_fifo_push === 1'b1) begin
            rx_q.push_back(tx_fifo_data);
            if (first_push_cyc < 0) first_push_cyc = cyc;
        end
        if (o_drop === 1'b1) drop_cnt++;

        if (rst) begin
            m_ok     = 1'b1;
            m_active = 1'b0;
            m_drop   = 1'b0;
        end else if (m_ok) begin
            m_drop = i_dist_valid && m_active;
            if (!m_active) begin
                if (i_dist_valid) begin
                    d = (int'(i_dist) > 999) ? 999 : int'(i_dist);
                    m_frame[0] = 8'h30 + 8'(d / 100);
                    m_frame[1] = 8'h30 + 8'((d / 10) % 10);
                    m_frame[2] = 8'h30 + 8'(d % 10);
`ifdef DIST_UNIT_EN
                    m_frame[3] = "c";
                    m_frame[4] = "m";
                    m_frame[5] = 8'h0D;
                    m_frame[6] = 8'h0A;
`else
                    m_frame[3] = 8'h0D;
                    m_frame[4] = 8'h0A;
                    m_frame[5] = 8'h00;
                    m_frame[6] = 8'h00;
`endif
                    m_wait     = d / 100 + (d / 10) % 10 + 2;
                    m_idx      = 0;
                    m_active   = 1'b1;
                    accept_cyc = cyc;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (!tx_fifo_full) begin
                m_idx++;
                if (m_idx == TB_LEN) m_active = 1'b0;
            end
        end
    end

    task automatic req(input logic [DIST_W-1:0] v);
        @(posedge clk);
        #1;
        i_dist       = v;
        i_dist_valid = 1'b1;
        @(posedge clk);
        #1;
        i_dist_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_busy === 1'b0 && !m_active) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_first_push(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (first_push_cyc >= 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_push_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    task automatic check_frame(input string digits);
        logic [7:0] exp_b [0:6];
        exp_b[0] = digits[0];
        exp_b[1] = digits[1];
        exp_b[2] = digits[2];
`ifdef DIST_UNIT_EN
        exp_b[3] = 8'h63;
        exp_b[4] = 8'h6D;
        exp_b[5] = 8'h0D;
        exp_b[6] = 8'h0A;
`else
        exp_b[3] = 8'h0D;
        exp_b[4] = 8'h0A;
        exp_b[5] = 8'h00;
        exp_b[6] = 8'h00;
`endif
        check({"len_", digits}, rx_q.size(), TB_LEN);
        for (int i = 0; i < TB_LEN && i < rx_q.size(); i++) begin
            check($sformatf("byte%0d_%s", i, digits), {24'b0, rx_q[i]}, {24'b0, exp_b[i]});
        end
    endtask

    task automatic run_frame(input logic [DIST_W-1:0] v, input string digits, input int lat);
        rx_q.delete();
        first_push_cyc = -1;
        req(v);
        wait_idle(digits);
        check_frame(digits);
        check({"latency_", digits}, first_push_cyc - accept_cyc, lat);
    endtask

    initial begin
        bit ok;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst          = 1'b1;
        i_dist       = '0;
        i_dist_valid = 1'b0;
        tx_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_data", {24'b0, tx_fifo_data}, 32'h00);
        check("rst_push", {31'b0, tx_fifo_push}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_drop", {31'b0, o_drop}, 32'd0);

        run_frame(10'd123, "123", 6);
        run_frame(10'd0, "000", 3);
        run_frame(10'd511, "511", 9);
        run_frame(10'd1023, "999", 21);

        // Back-pressure held for 10 cycles after the first byte.
        rx_q.delete();
        first_push_cyc = -1;
        req(10'd45);
        wait_first_push("full");
        @(posedge clk);
        #1 tx_fifo_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("push_while_full", {31'b0, tx_fifo_push}, 32'd0);
        end
        @(posedge clk);
        #1 tx_fifo_full = 1'b0;
        wait_idle("full");
        check_frame("045");

        // Second request while the frame is in progress.
        rx_q.delete();
        first_push_cyc = -1;
        req(10'd200);
        wait_first_push("drop");
        drop_cnt = 0;
        req(10'd77);
        wait_idle("drop");
        repeat (5) @(negedge clk);
        check("drop_count", drop_cnt, 32'd1);
        check_frame("200");

        // Reset after the second byte aborts the frame.
        rx_q.delete();
        first_push_cyc = -1;
        req(10'd345);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_wait_timeout", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_data", {24'b0, tx_fifo_data}, 32'h00);
        check("midrst_push", {31'b0, tx_fifo_push}, 32'd0);
        check("midrst_busy", {31'b0, o_busy}, 32'd0);
        check("midrst_aborted", {31'b0, (rx_q.size() < TB_LEN)}, 32'd1);
        repeat (4) @(negedge clk);
        run_frame(10'd88, "088", 11);

        // Randomised requests, stray strobes and back-pressure against the model.
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            i_dist       = 10'($urandom_range(0, 1023));
            i_dist_valid = 1'b1;
            tx_fifo_full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 80; k++) begin
                @(posedge clk);
                #1;
                i_dist_valid = ($urandom_range(0, 15) == 0);
                i_dist       = 10'($urandom_range(0, 1023));
                tx_fifo_full = ($urandom_range(0, 3) == 0);
            end
        end
        @(posedge clk);
        #1;
        i_dist_valid = 1'b0;
        tx_fifo_full = 1'b0;
        wait_idle("random");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
